// File: rtl/scariv_bru_upd_arb.sv
// -----------------------------------------------------------------------------
// scariv_bru_upd_arb
//
// Purpose:
//   Merges branch resolutions from PIPE_NUM BRU ex3 pipes into a single
//   registered mispredict update and a set of per-pipe brtag releases.
//   - The oldest mispredict wins. An exact age tie goes to the lowest pipe
//     index.
//   - After a mispredict is emitted, the arbiter waits in FLUSH_WAIT until
//     i_flush_done arrives.
//   - While waiting, anything at or younger than the held flush point is
//     squashed. Only strictly older resolutions pass.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_upd_valid/_mispred    per-pipe resolution valid / mispredict flag
//   i_upd_cmt_id/_grp_id    per-pipe age (commit id with wrap MSB, one-hot grp)
//   i_upd_brtag/_target     per-pipe branch tag / redirect target
//   i_flush_done            commit stage finished the redirect flush
//   o_br_upd_*              registered single mispredict update (1-cycle pulse)
//   o_release_valid/_brtag  registered per-pipe release of correct branches
//   o_flush_pending         high while in FLUSH_WAIT
//   o_mispred_count         (only with SCARIV_BRU_UPD_STAT_EN) saturating
//                           count of emitted mispredicts
//
// Optional feature macro: SCARIV_BRU_UPD_STAT_EN
// -----------------------------------------------------------------------------
module scariv_bru_upd_arb #(
   parameter int PIPE_NUM = 2,
   parameter int CMT_ID_W = 7,
   parameter int GRP_W    = 4,
   parameter int BRTAG_W  = 4,
   parameter int VADDR_W  = 39
) (
   input  logic                               i_clk,
   input  logic                               i_reset_n,
   input  logic [PIPE_NUM-1:0]                i_upd_valid,
   input  logic [PIPE_NUM-1:0]                i_upd_mispred,
   input  logic [PIPE_NUM-1:0][CMT_ID_W-1:0]  i_upd_cmt_id,
   input  logic [PIPE_NUM-1:0][GRP_W-1:0]     i_upd_grp_id,
   input  logic [PIPE_NUM-1:0][BRTAG_W-1:0]   i_upd_brtag,
   input  logic [PIPE_NUM-1:0][VADDR_W-1:0]   i_upd_target,
   input  logic                               i_flush_done,
   output logic                               o_br_upd_valid,
   output logic [CMT_ID_W-1:0]                o_br_upd_cmt_id,
   output logic [GRP_W-1:0]                   o_br_upd_grp_id,
   output logic [BRTAG_W-1:0]                 o_br_upd_brtag,
   output logic [VADDR_W-1:0]                 o_br_upd_target,
   output logic [PIPE_NUM-1:0]                o_release_valid,
   output logic [PIPE_NUM-1:0][BRTAG_W-1:0]   o_release_brtag,
   output logic                               o_flush_pending
`ifdef SCARIV_BRU_UPD_STAT_EN
   ,
   output logic [31:0]                        o_mispred_count
`endif
);

   typedef enum logic [0:0] {ST_IDLE, ST_FLUSH_WAIT} state_t;

   // Returns 1 when A is strictly older than B.
   // The MSB of the commit id is a wrap bit:
   //   - wrap bits equal:  the smaller low part is older;
   //   - wrap bits differ: the larger low part is older.
   // At the same commit id, the lower one-hot group bit is older. That means
   // the numerically smaller one-hot vector is older.
   function automatic logic is_older(input logic [CMT_ID_W-1:0] a_cmt,
                                     input logic [GRP_W-1:0]    a_grp,
                                     input logic [CMT_ID_W-1:0] b_cmt,
                                     input logic [GRP_W-1:0]    b_grp);
      logic res;
      if (a_cmt == b_cmt) begin
         res = (a_grp < b_grp);
      end else if (a_cmt[CMT_ID_W-1] == b_cmt[CMT_ID_W-1]) begin
         res = (a_cmt[CMT_ID_W-2:0] < b_cmt[CMT_ID_W-2:0]);
      end else begin
         res = (a_cmt[CMT_ID_W-2:0] > b_cmt[CMT_ID_W-2:0]);
      end
      return res;
   endfunction

   state_t                     state_q, state_d;
   logic [CMT_ID_W-1:0]        held_cmt_q, held_cmt_d;
   logic [GRP_W-1:0]           held_grp_q, held_grp_d;

   logic [PIPE_NUM-1:0]        live;     // survives the flush-point filter
   logic [PIPE_NUM-1:0]        cand;     // live mispredict
   logic [PIPE_NUM-1:0]        rel;      // live correct branch to release

   logic                       sel_valid;
   logic [CMT_ID_W-1:0]        sel_cmt;
   logic [GRP_W-1:0]           sel_grp;
   logic [BRTAG_W-1:0]         sel_brtag;
   logic [VADDR_W-1:0]         sel_target;

   logic                       upd_valid_q;
   logic [CMT_ID_W-1:0]        upd_cmt_q;
   logic [GRP_W-1:0]           upd_grp_q;
   logic [BRTAG_W-1:0]         upd_brtag_q;
   logic [VADDR_W-1:0]         upd_target_q;
   logic [PIPE_NUM-1:0]        rel_valid_q;
   logic [PIPE_NUM-1:0][BRTAG_W-1:0] rel_brtag_q;

   // In FLUSH_WAIT, only resolutions strictly older than the held point survive.
   for (genvar gi = 0; gi < PIPE_NUM; gi++) begin : g_filter
      assign live[gi] = i_upd_valid[gi] &
                        ((state_q == ST_IDLE) |
                         is_older(i_upd_cmt_id[gi], i_upd_grp_id[gi], held_cmt_q, held_grp_q));
      assign cand[gi] = live[gi] & i_upd_mispred[gi];
   end

   // Oldest-mispredict pick.
   // A later pipe replaces the current pick only when it is strictly older.
   // An exact tie therefore keeps the lower pipe index.
   always_comb begin
      sel_valid  = 1'b0;
      sel_cmt    = '0;
      sel_grp    = '0;
      sel_brtag  = '0;
      sel_target = '0;
      for (int p = 0; p < PIPE_NUM; p++) begin
         if (cand[p] && (!sel_valid ||
                         is_older(i_upd_cmt_id[p], i_upd_grp_id[p], sel_cmt, sel_grp))) begin
            sel_valid  = 1'b1;
            sel_cmt    = i_upd_cmt_id[p];
            sel_grp    = i_upd_grp_id[p];
            sel_brtag  = i_upd_brtag[p];
            sel_target = i_upd_target[p];
         end
      end
   end

   // A correct branch is released only if it is strictly older than any
   // mispredict accepted in the same cycle. Otherwise that mispredict's
   // flush kills it.
   for (genvar gi = 0; gi < PIPE_NUM; gi++) begin : g_release
      assign rel[gi] = live[gi] & ~i_upd_mispred[gi] &
                       (~sel_valid |
                        is_older(i_upd_cmt_id[gi], i_upd_grp_id[gi], sel_cmt, sel_grp));
   end

   // A newly accepted mispredict always (re)arms FLUSH_WAIT. It takes
   // priority over a same-cycle i_flush_done, because the new redirect
   // still needs its own flush.
   always_comb begin
      state_d    = state_q;
      held_cmt_d = held_cmt_q;
      held_grp_d = held_grp_q;
      if (sel_valid) begin
         state_d    = ST_FLUSH_WAIT;
         held_cmt_d = sel_cmt;
         held_grp_d = sel_grp;
      end else if ((state_q == ST_FLUSH_WAIT) && i_flush_done) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         held_cmt_q   <= '0;
         held_grp_q   <= '0;
         upd_valid_q  <= 1'b0;
         upd_cmt_q    <= '0;
         upd_grp_q    <= '0;
         upd_brtag_q  <= '0;
         upd_target_q <= '0;
         rel_valid_q  <= '0;
         rel_brtag_q  <= '0;
      end else begin
         state_q     <= state_d;
         held_cmt_q  <= held_cmt_d;
         held_grp_q  <= held_grp_d;
         upd_valid_q <= sel_valid;
         if (sel_valid) begin
            upd_cmt_q    <= sel_cmt;
            upd_grp_q    <= sel_grp;
            upd_brtag_q  <= sel_brtag;
            upd_target_q <= sel_target;
         end
         rel_valid_q <= rel;
         for (int p = 0; p < PIPE_NUM; p++) begin
            if (rel[p]) begin
               rel_brtag_q[p] <= i_upd_brtag[p];
            end
         end
      end
   end

   assign o_br_upd_valid  = upd_valid_q;
   assign o_br_upd_cmt_id = upd_cmt_q;
   assign o_br_upd_grp_id = upd_grp_q;
   assign o_br_upd_brtag  = upd_brtag_q;
   assign o_br_upd_target = upd_target_q;
   assign o_release_valid = rel_valid_q;
   assign o_release_brtag = rel_brtag_q;
   assign o_flush_pending = (state_q == ST_FLUSH_WAIT);

`ifdef SCARIV_BRU_UPD_STAT_EN
   // Counts on the same edge that raises o_br_upd_valid, so the value
   // already includes the pulse currently being shown. Saturates at all-ones.
   logic [31:0] mispred_count_q;
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mispred_count_q <= '0;
      end else if (sel_valid && (mispred_count_q != 32'hFFFF_FFFF)) begin
         mispred_count_q <= mispred_count_q + 32'd1;
      end
   end
   assign o_mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_scariv_bru_upd_arb.sv
// -----------------------------------------------------------------------------
// tb_scariv_bru_upd_arb
//
// Testbench for scariv_bru_upd_arb with its default parameters.
//
// Stimulus and checking:
//   - A directed vector table is applied in sequence, covering:
//       * plain age ordering;
//       * cmt_id wrap-around;
//       * held-point squash and replacement;
//       * group-id tie-break;
//       * release versus mispredict;
//       * i_flush_done.
//   - A reset asserted mid-FLUSH_WAIT is checked.
//   - Random traffic is checked against a reference model. The model
//     measures age as the modular distance between commit ids.
//
// Optional feature macro: SCARIV_BRU_UPD_STAT_EN
// -----------------------------------------------------------------------------
module tb_scariv_bru_upd_arb;

   localparam int P  = 2;
   localparam int CW = 7;
   localparam int GW = 4;
   localparam int BW = 4;
   localparam int VW = 39;

   logic                   clk;
   logic                   rst_n;
   logic [P-1:0]           upd_valid;
   logic [P-1:0]           upd_mispred;
   logic [P-1:0][CW-1:0]   upd_cmt;
   logic [P-1:0][GW-1:0]   upd_grp;
   logic [P-1:0][BW-1:0]   upd_brtag;
   logic [P-1:0][VW-1:0]   upd_target;
   logic                   flush_done;
   logic                   br_valid;
   logic [CW-1:0]          br_cmt;
   logic [GW-1:0]          br_grp;
   logic [BW-1:0]          br_brtag;
   logic [VW-1:0]          br_target;
   logic [P-1:0]           rel_valid;
   logic [P-1:0][BW-1:0]   rel_brtag;
   logic                   pending;
`ifdef SCARIV_BRU_UPD_STAT_EN
   logic [31:0]            mis_count;
`endif

   int checks;
   int failures;

   scariv_bru_upd_arb #(
      .PIPE_NUM (P),
      .CMT_ID_W (CW),
      .GRP_W    (GW),
      .BRTAG_W  (BW),
      .VADDR_W  (VW)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_upd_valid     (upd_valid),
      .i_upd_mispred   (upd_mispred),
      .i_upd_cmt_id    (upd_cmt),
      .i_upd_grp_id    (upd_grp),
      .i_upd_brtag     (upd_brtag),
      .i_upd_target    (upd_target),
      .i_flush_done    (flush_done),
      .o_br_upd_valid  (br_valid),
      .o_br_upd_cmt_id (br_cmt),
      .o_br_upd_grp_id (br_grp),
      .o_br_upd_brtag  (br_brtag),
      .o_br_upd_target (br_target),
      .o_release_valid (rel_valid),
      .o_release_brtag (rel_brtag),
      .o_flush_pending (pending)
`ifdef SCARIV_BRU_UPD_STAT_EN
      ,
      .o_mispred_count (mis_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each check prints one line with FAIL, a name, the actual value and
   // the expected value.
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // The target is derived from the brtag, so the payload can be checked
   // from the brtag alone.
   function automatic logic [VW-1:0] tgt_of(input logic [BW-1:0] b);
      return VW'(39'h40_0000) + (VW'(b) << 2);
   endfunction

   // ---------------- reference model ----------------
   bit               mdl_busy;
   logic [CW-1:0]    mdl_hc;
   logic [GW-1:0]    mdl_hg;
   logic             me_v;
   logic [CW-1:0]    me_c;
   logic [GW-1:0]    me_g;
   logic [BW-1:0]    me_b;
   logic [P-1:0]     me_rv;
   logic [P-1:0][BW-1:0] me_rb;
   logic             me_p;

   function automatic int lowbit(input logic [GW-1:0] g);
      int r;
      r = GW;
      for (int i = GW - 1; i >= 0; i--) if (g[i]) r = i;
      return r;
   endfunction

   // A is older than B when B lies within the first half of the commit-id
   // ring ahead of A.
   function automatic bit m_older(input logic [CW-1:0] ac, input logic [GW-1:0] ag,
                                  input logic [CW-1:0] bc, input logic [GW-1:0] bg);
      int d;
      d = (int'(bc) - int'(ac) + (1 << CW)) % (1 << CW);
      if (d == 0) return lowbit(ag) < lowbit(bg);
      return d < (1 << (CW - 1));
   endfunction

   task automatic mdl_step();
      bit live[P];
      int win;
      bit beaten;
      win = -1;
      for (int p = 0; p < P; p++)
         live[p] = upd_valid[p] &&
                   (!mdl_busy || m_older(upd_cmt[p], upd_grp[p], mdl_hc, mdl_hg));
      // The winner is a live mispredict that no other live mispredict beats.
      // A beater is strictly older, or equal in age with a lower pipe index.
      for (int p = 0; p < P; p++) begin
         if (live[p] && upd_mispred[p]) begin
            beaten = 0;
            for (int q = 0; q < P; q++) begin
               if (q != p && live[q] && upd_mispred[q] &&
                   (m_older(upd_cmt[q], upd_grp[q], upd_cmt[p], upd_grp[p]) ||
                    (q < p && !m_older(upd_cmt[p], upd_grp[p], upd_cmt[q], upd_grp[q]))))
                  beaten = 1;
            end
            if (!beaten) win = p;
         end
      end
      me_v = (win >= 0);
      me_c = '0; me_g = '0; me_b = '0;
      if (win >= 0) begin
         me_c = upd_cmt[win];
         me_g = upd_grp[win];
         me_b = upd_brtag[win];
      end
      for (int p = 0; p < P; p++) begin
         me_rv[p] = live[p] && !upd_mispred[p] &&
                    (win < 0 || m_older(upd_cmt[p], upd_grp[p], me_c, me_g));
         me_rb[p] = upd_brtag[p];
      end
      if (win >= 0) begin
         mdl_busy = 1;
         mdl_hc   = me_c;
         mdl_hg   = me_g;
      end else if (mdl_busy && flush_done) begin
         mdl_busy = 0;
      end
      me_p = mdl_busy;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0]    v, m;
      logic [CW-1:0] c0, c1;
      logic [GW-1:0] g0, g1;
      logic [BW-1:0] b0, b1;
      logic          fd;
      logic          ev;
      logic [CW-1:0] ec;
      logic [GW-1:0] eg;
      logic [BW-1:0] eb;
      logic [1:0]    erv;
      logic [BW-1:0] erb0, erb1;
      logic          ep;
   } vec_t;

   vec_t tab[15];

   task automatic set_row(input int i, input logic [1:0] v, input logic [1:0] m,
                          input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                          input logic [GW-1:0] g0, input logic [GW-1:0] g1,
                          input logic [BW-1:0] b0, input logic [BW-1:0] b1, input logic fd,
                          input logic ev, input logic [CW-1:0] ec, input logic [GW-1:0] eg,
                          input logic [BW-1:0] eb, input logic [1:0] erv,
                          input logic [BW-1:0] erb0, input logic [BW-1:0] erb1, input logic ep);
      tab[i].v = v;   tab[i].m = m;   tab[i].c0 = c0; tab[i].c1 = c1;
      tab[i].g0 = g0; tab[i].g1 = g1; tab[i].b0 = b0; tab[i].b1 = b1;
      tab[i].fd = fd; tab[i].ev = ev; tab[i].ec = ec; tab[i].eg = eg;
      tab[i].eb = eb; tab[i].erv = erv; tab[i].erb0 = erb0; tab[i].erb1 = erb1;
      tab[i].ep = ep;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] m,
                        input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                        input logic [GW-1:0] g0, input logic [GW-1:0] g1,
                        input logic [BW-1:0] b0, input logic [BW-1:0] b1, input logic fd);
      upd_valid     = v;
      upd_mispred   = m;
      upd_cmt[0]    = c0;
      upd_cmt[1]    = c1;
      upd_grp[0]    = g0;
      upd_grp[1]    = g1;
      upd_brtag[0]  = b0;
      upd_brtag[1]  = b1;
      upd_target[0] = tgt_of(b0);
      upd_target[1] = tgt_of(b1);
      flush_done    = fd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [CW-1:0] rbase;

   initial begin
      checks   = 0;
      failures = 0;
      mdl_busy = 0;
      mdl_hc   = '0;
      mdl_hg   = '0;
      rst_n    = 1'b0;
      drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 1'b0);

      // Reset state
      #12;
      chk("reset_upd_valid", 64'(br_valid), 64'd0);
      chk("reset_pending",   64'(pending),  64'd0);
      chk("reset_rel_valid", 64'(rel_valid), 64'd0);
      chk("reset_upd_cmt",   64'(br_cmt),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table, applied in order; FSM state carries between rows.
      //       idx v      m      c0     c1     g0 g1 b0 b1 fd  ev ec     eg eb  erv   erb0 erb1 ep
      set_row(0,  2'b11, 2'b11, 7'h05, 7'h03, 1, 1, 1, 2, 0,  1, 7'h03, 1, 2,  2'b00, 0, 0, 1); // older of two mispreds
      set_row(1,  2'b00, 2'b00, 7'h00, 7'h00, 1, 1, 0, 0, 1,  0, 7'h00, 0, 0,  2'b00, 0, 0, 0); // flush done
      set_row(2,  2'b11, 2'b11, 7'h7E, 7'h01, 1, 1, 3, 4, 0,  1, 7'h7E, 1, 3,  2'b00, 0, 0, 1); // wrap-around
      set_row(3,  2'b00, 2'b00, 7'h00, 7'h00, 1, 1, 0, 0, 1,  0, 7'h00, 0, 0,  2'b00, 0, 0, 0);
      set_row(4,  2'b01, 2'b01, 7'h10, 7'h00, 1, 1, 5, 0, 0,  1, 7'h10, 1, 5,  2'b00, 0, 0, 1); // held 0x10
      set_row(5,  2'b01, 2'b01, 7'h12, 7'h00, 1, 1, 6, 0, 0,  0, 7'h00, 0, 0,  2'b00, 0, 0, 1); // younger squashed
      set_row(6,  2'b10, 2'b10, 7'h00, 7'h0C, 1, 1, 0, 7, 0,  1, 7'h0C, 1, 7,  2'b00, 0, 0, 1); // older replaces
      set_row(7,  2'b11, 2'b01, 7'h0E, 7'h0B, 1, 1, 8, 5, 0,  0, 7'h00, 0, 0,  2'b10, 0, 5, 1); // held now 0x0C
      set_row(8,  2'b00, 2'b00, 7'h00, 7'h00, 1, 1, 0, 0, 1,  0, 7'h00, 0, 0,  2'b00, 0, 0, 0);
      set_row(9,  2'b11, 2'b11, 7'h08, 7'h08, 4, 2, 6, 7, 0,  1, 7'h08, 2, 7,  2'b00, 0, 0, 1); // grp tie-break
      set_row(10, 2'b00, 2'b00, 7'h00, 7'h00, 1, 1, 0, 0, 1,  0, 7'h00, 0, 0,  2'b00, 0, 0, 0);
      set_row(11, 2'b11, 2'b10, 7'h02, 7'h04, 1, 1, 3, 9, 0,  1, 7'h04, 1, 9,  2'b01, 3, 0, 1); // release + update
      set_row(12, 2'b11, 2'b00, 7'h01, 7'h06, 1, 1, 4, 2, 1,  0, 7'h00, 0, 0,  2'b01, 4, 0, 0); // filter on flush_done
      set_row(13, 2'b11, 2'b00, 7'h06, 7'h07, 1, 1, 1, 2, 0,  0, 7'h00, 0, 0,  2'b11, 1, 2, 0); // parallel release
      set_row(14, 2'b11, 2'b10, 7'h09, 7'h08, 1, 1, 3, 5, 0,  1, 7'h08, 1, 5,  2'b00, 0, 0, 1); // younger correct squashed

      for (int i = 0; i < 15; i++) begin
         drive(tab[i].v, tab[i].m, tab[i].c0, tab[i].c1, tab[i].g0, tab[i].g1,
               tab[i].b0, tab[i].b1, tab[i].fd);
         mdl_step();
         tick();
         $display("vec %0d: upd=%0b cmt=0x%0h rel=%b pend=%0b", i, br_valid, br_cmt, rel_valid, pending);
         chk($sformatf("vec%0d_upd_valid", i), 64'(br_valid), 64'(tab[i].ev));
         chk($sformatf("vec%0d_rel_valid", i), 64'(rel_valid), 64'(tab[i].erv));
         chk($sformatf("vec%0d_pending", i),   64'(pending),  64'(tab[i].ep));
         if (tab[i].ev) begin
            chk($sformatf("vec%0d_upd_cmt", i),    64'(br_cmt),    64'(tab[i].ec));
            chk($sformatf("vec%0d_upd_grp", i),    64'(br_grp),    64'(tab[i].eg));
            chk($sformatf("vec%0d_upd_brtag", i),  64'(br_brtag),  64'(tab[i].eb));
            chk($sformatf("vec%0d_upd_target", i), 64'(br_target), 64'(tgt_of(tab[i].eb)));
         end
         if (tab[i].erv[0]) chk($sformatf("vec%0d_rel_brtag0", i), 64'(rel_brtag[0]), 64'(tab[i].erb0));
         if (tab[i].erv[1]) chk($sformatf("vec%0d_rel_brtag1", i), 64'(rel_brtag[1]), 64'(tab[i].erb1));
      end

      // Asynchronous reset mid-FLUSH_WAIT (held point is 0x08), with no clock edge.
      drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("midrst_upd_valid", 64'(br_valid),  64'd0);
      chk("midrst_upd_cmt",   64'(br_cmt),    64'd0);
      chk("midrst_upd_brtag", 64'(br_brtag),  64'd0);
      chk("midrst_upd_target", 64'(br_target), 64'd0);
      chk("midrst_rel_brtag", 64'(rel_brtag), 64'd0);
      chk("midrst_pending",   64'(pending),   64'd0);
`ifdef SCARIV_BRU_UPD_STAT_EN
      chk("midrst_count",     64'(mis_count), 64'd0);
`endif
      #1;
      rst_n    = 1'b1;
      mdl_busy = 0;
      mdl_hc   = '0;
      mdl_hg   = '0;

      // 0x30 is younger than the discarded held point 0x08.
      // It must still be accepted, because the arbiter is back in IDLE.
      drive(2'b01, 2'b01, 7'h30, 7'h00, 1, 1, 4'hA, 0, 1'b0);
      mdl_step();
      tick();
      $display("post-reset: upd=%0b cmt=0x%0h pend=%0b", br_valid, br_cmt, pending);
      chk("postrst_upd_valid", 64'(br_valid), 64'd1);
      chk("postrst_upd_cmt",   64'(br_cmt),   64'h30);
      chk("postrst_pending",   64'(pending),  64'd1);

      // Randomized traffic against the model.
      rbase = 7'h30;
      for (int n = 0; n < 1500; n++) begin
         logic [1:0] v, m;
         logic [CW-1:0] c0, c1;
         logic [GW-1:0] g0, g1;
         logic [BW-1:0] b0, b1;
         rbase = rbase + CW'($urandom_range(0, 3));
         v  = 2'($urandom);
         m  = 2'($urandom);
         c0 = rbase + CW'($urandom_range(0, 12));
         c1 = rbase + CW'($urandom_range(0, 12));
         g0 = GW'(1 << $urandom_range(0, GW - 1));
         g1 = GW'(1 << $urandom_range(0, GW - 1));
         if ($urandom_range(0, 4) == 0) begin
            c1 = c0;
            if ($urandom_range(0, 1) == 0) g1 = g0;
         end
         b0 = BW'($urandom);
         b1 = BW'($urandom);
         drive(v, m, c0, c1, g0, g1, b0, b1, ($urandom_range(0, 9) < 3));
         mdl_step();
         tick();
         $display("rnd %0d: upd=%0b cmt=0x%0h rel=%b pend=%0b", n, br_valid, br_cmt, rel_valid, pending);
         chk("rnd_upd_valid", 64'(br_valid),  64'(me_v));
         chk("rnd_rel_valid", 64'(rel_valid), 64'(me_rv));
         chk("rnd_pending",   64'(pending),   64'(me_p));
         if (me_v) begin
            chk("rnd_upd_cmt",    64'(br_cmt),    64'(me_c));
            chk("rnd_upd_grp",    64'(br_grp),    64'(me_g));
            chk("rnd_upd_brtag",  64'(br_brtag),  64'(me_b));
            chk("rnd_upd_target", 64'(br_target), 64'(tgt_of(me_b)));
         end
         for (int p = 0; p < P; p++)
            if (me_rv[p]) chk($sformatf("rnd_rel_brtag%0d", p), 64'(rel_brtag[p]), 64'(me_rb[p]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
